// File: rtl/retospect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retospect_pkg: shared constants, default widths and neuron state encoding. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package retospect_pkg;

  localparam int CLOCKBUS_W = 8;
  localparam int CB_NEVER   = 0;
  localparam int CB_ALWAYS  = 1;

  localparam int W_WIDTH    = 3;
  localparam int UT_WIDTH   = 4;
  localparam int V_WIDTH    = 6;

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACTORY = 2'd2
  } lif_state_e;

endpackage
`default_nettype wire

// File: rtl/retospect_syn_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retospect_syn_adder: gates four synapse weights and adds them to the       |
// | leaked potential, clamping at the potential's maximum. Rev 1.0             |
// +----------------------------------------------------------------------------+
module retospect_syn_adder #(
  parameter int W_WIDTH = 3,
  parameter int V_WIDTH = 6
) (
  input  logic [4*W_WIDTH-1:0] i_w,
  input  logic [3:0]           i_syn,
  input  logic [V_WIDTH-1:0]   i_v,
  output logic [V_WIDTH-1:0]   o_v
);

  localparam int SUM_W = W_WIDTH + 2;
  localparam int ACC_W = ((V_WIDTH > SUM_W) ? V_WIDTH : SUM_W) + 1;
  localparam logic [ACC_W-1:0] c_vmax = {{(ACC_W-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}};

  logic [W_WIDTH-1:0] w_gated [4];
  logic [SUM_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_acc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_syn
    assign w_gated[gi] = i_syn[gi] ? i_w[gi*W_WIDTH +: W_WIDTH] : '0;
  end

  // Four W-bit terms fit in W+2 bits, so the weight sum itself never overflows.
  assign w_sum = SUM_W'(w_gated[0]) + SUM_W'(w_gated[1])
               + SUM_W'(w_gated[2]) + SUM_W'(w_gated[3]);
  assign w_acc = ACC_W'(i_v) + ACC_W'(w_sum);
  assign o_v   = (w_acc > c_vmax) ? c_vmax[V_WIDTH-1:0] : w_acc[V_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/retospect_lif_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retospect_lif_neuron: leaky integrate-and-fire neuron with one-cycle spike |
// | and refractory period. Rev 1.0                                             |
// +----------------------------------------------------------------------------+
module retospect_lif_neuron #(
  parameter int W_WIDTH  = retospect_pkg::W_WIDTH,
  parameter int UT_WIDTH = retospect_pkg::UT_WIDTH,
  parameter int V_WIDTH  = retospect_pkg::V_WIDTH,
  parameter int REFRACT  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                reset_nn,
  input  logic                                config_en,
  input  logic [4*W_WIDTH-1:0]                w,
  input  logic [UT_WIDTH-1:0]                 u_t,
  input  logic [2:0]                          decay_sel,
  input  logic [retospect_pkg::CLOCKBUS_W-1:0] clockbus,
  input  logic [3:0]                          syn_in,
  output logic                                spike_out,
  output logic [V_WIDTH-1:0]                  v_mem
);

  import retospect_pkg::*;

  localparam int CNT_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int CMP_W = (V_WIDTH > UT_WIDTH) ? V_WIDTH : UT_WIDTH;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'((REFRACT > 0) ? REFRACT - 1 : 0);

  lif_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [V_WIDTH-1:0] w_v_nxt;
  logic               w_spike_nxt;
  logic               w_leak;
  logic [V_WIDTH-1:0] w_v_leaked;
  logic [V_WIDTH-1:0] w_v_sum;
  logic               w_fire;

  // Leak is applied before the synaptic add and floors at zero.
  assign w_leak     = clockbus[decay_sel];
  assign w_v_leaked = (w_leak && (v_mem != '0)) ? (v_mem - V_WIDTH'(1)) : v_mem;

  retospect_syn_adder #(
    .W_WIDTH (W_WIDTH),
    .V_WIDTH (V_WIDTH)
  ) u_syn_adder (
    .i_w   (w),
    .i_syn (syn_in),
    .i_v   (w_v_leaked),
    .o_v   (w_v_sum)
  );

  assign w_fire = CMP_W'(w_v_sum) >= CMP_W'(u_t);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_v_nxt     = v_mem;
    w_spike_nxt = 1'b0;
    if (reset_nn) begin
      w_state_nxt = ST_INTEGRATE;
      w_cnt_nxt   = '0;
      w_v_nxt     = '0;
    end else if (!config_en) begin
      case (r_state)
        ST_INTEGRATE: begin
          if (w_fire) begin
            w_v_nxt     = '0;
            w_spike_nxt = 1'b1;
            w_state_nxt = ST_FIRE;
          end else begin
            w_v_nxt = w_v_sum;
          end
        end
        ST_FIRE: begin
          if (REFRACT > 0) begin
            w_cnt_nxt   = c_cnt_init;
            w_state_nxt = ST_REFRACTORY;
          end else begin
            w_state_nxt = ST_INTEGRATE;
          end
        end
        ST_REFRACTORY: begin
          w_v_nxt = '0;
          if (r_cnt == '0) begin
            w_state_nxt = ST_INTEGRATE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_INTEGRATE;
          w_cnt_nxt   = '0;
          w_v_nxt     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INTEGRATE;
      r_cnt     <= '0;
      v_mem     <= '0;
      spike_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      v_mem     <= w_v_nxt;
      spike_out <= w_spike_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retospect_lif_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_retospect_lif_neuron: three neuron variants driven in parallel against  |
// | an integer reference model. Rev 1.0                                        |
// +----------------------------------------------------------------------------+
module tb_retospect_lif_neuron;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reset_nn;
  logic        config_en;
  logic [11:0] w;
  logic [3:0]  u_t;
  logic [2:0]  decay_sel;
  logic [7:0]  clockbus;
  logic [3:0]  syn_in;

  logic        spk_a, spk_b, spk_c;
  logic [5:0]  v_a, v_b;
  logic [3:0]  v_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // a: defaults; b: no refractory period; c: narrow potential to reach saturation.
  retospect_lif_neuron #(.W_WIDTH(3), .UT_WIDTH(4), .V_WIDTH(6), .REFRACT(2)) dut (
    .clk(clk), .rst_n(rst_n), .reset_nn(reset_nn), .config_en(config_en), .w(w),
    .u_t(u_t), .decay_sel(decay_sel), .clockbus(clockbus), .syn_in(syn_in),
    .spike_out(spk_a), .v_mem(v_a));
  retospect_lif_neuron #(.W_WIDTH(3), .UT_WIDTH(4), .V_WIDTH(6), .REFRACT(0)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .reset_nn(reset_nn), .config_en(config_en), .w(w),
    .u_t(u_t), .decay_sel(decay_sel), .clockbus(clockbus), .syn_in(syn_in),
    .spike_out(spk_b), .v_mem(v_b));
  retospect_lif_neuron #(.W_WIDTH(3), .UT_WIDTH(4), .V_WIDTH(4), .REFRACT(2)) dut_v4 (
    .clk(clk), .rst_n(rst_n), .reset_nn(reset_nn), .config_en(config_en), .w(w),
    .u_t(u_t), .decay_sel(decay_sel), .clockbus(clockbus), .syn_in(syn_in),
    .spike_out(spk_c), .v_mem(v_c));

  // quiet = number of upcoming cycles in which the neuron ignores its inputs after a spike
  typedef struct {
    int v;
    int spk;
    int quiet;
  } mdl_t;

  mdl_t m_a, m_b, m_c;

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int vmax, input int refract);
    mdl_t n;
    int   sum;
    int   vl;
    logic [11:0] wv;
    n     = m;
    n.spk = 0;
    wv    = w;
    if (reset_nn) begin
      n.v     = 0;
      n.quiet = 0;
    end else if (config_en) begin
      n.quiet = m.quiet;
    end else if (m.quiet > 0) begin
      n.quiet = m.quiet - 1;
    end else begin
      sum = 0;
      for (int i = 0; i < 4; i++)
        if (syn_in[i]) sum += int'(wv[i*3 +: 3]);
      vl = m.v;
      if (clockbus[decay_sel] && vl > 0) vl = vl - 1;
      vl = vl + sum;
      if (vl > vmax) vl = vmax;
      if (vl >= int'(u_t)) begin
        n.v     = 0;
        n.spk   = 1;
        n.quiet = refract + 1;
      end else begin
        n.v = vl;
      end
    end
    return n;
  endfunction

  task automatic compare_all();
    check("a_v",   int'(v_a),   m_a.v);
    check("a_spk", int'(spk_a), m_a.spk);
    check("b_v",   int'(v_b),   m_b.v);
    check("b_spk", int'(spk_b), m_b.spk);
    check("c_v",   int'(v_c),   m_c.v);
    check("c_spk", int'(spk_c), m_c.spk);
  endtask

  task automatic tick();
    @(posedge clk);
    m_a = step(m_a, 63, 2);
    m_b = step(m_b, 63, 0);
    m_c = step(m_c, 15, 2);
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    m_a = '{0, 0, 0};
    m_b = '{0, 0, 0};
    m_c = '{0, 0, 0};
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_rst();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic soft_reset();
    reset_nn = 1'b1;
    tick();
    reset_nn = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    reset_nn  = 1'b0;
    config_en = 1'b0;
    w         = '0;
    u_t       = '0;
    decay_sel = '0;
    clockbus  = 8'b0000_0010;
    syn_in    = '0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Unit weights, threshold 10, no leak: 4, 8, then fire.
    w = {3'd1, 3'd1, 3'd1, 3'd1}; u_t = 4'd10; decay_sel = 3'd0; syn_in = 4'b1111;
    tick(); check("t1_v4", int'(v_a), 4);
    tick(); check("t1_v8", int'(v_a), 8);
    tick(); check("t1_fire", int'(spk_a), 1);
    tick(); check("t1_onecycle", int'(spk_a), 0);
    repeat (12) tick();

    // Preload 5, then leak every cycle down to zero without spiking.
    soft_reset();
    w = {3'd0, 3'd0, 3'd0, 3'd5}; u_t = 4'd15; syn_in = 4'b0001;
    tick(); check("t2_pre", int'(v_a), 5);
    syn_in = 4'b0000; decay_sel = 3'd1;
    tick(); check("t2_leak1", int'(v_a), 4);
    repeat (4) tick();
    check("t2_zero", int'(v_a), 0);
    repeat (3) tick();
    check("t2_floor", int'(v_a), 0);

    // Saturation: 10 + 7 clamps at 15 on the narrow variant and fires at u_t=15.
    soft_reset();
    decay_sel = 3'd0; w = {3'd0, 3'd0, 3'd5, 3'd5}; syn_in = 4'b0011;
    tick(); check("t3_pre", int'(v_c), 10);
    w = {3'd7, 3'd7, 3'd7, 3'd7}; syn_in = 4'b0001;
    tick(); check("t3_satfire", int'(spk_c), 1);
    syn_in = 4'b1111;
    repeat (8) tick();

    // Always-firing neuron.
    soft_reset();
    u_t = 4'd0; syn_in = 4'b0000;
    repeat (12) tick();

    // Configuration freeze at v=6.
    soft_reset();
    u_t = 4'd15; w = {3'd0, 3'd0, 3'd0, 3'd3}; syn_in = 4'b0001;
    repeat (2) tick();
    check("t5_pre", int'(v_a), 6);
    config_en = 1'b1; syn_in = 4'b1111; decay_sel = 3'd1;
    repeat (8) tick();
    check("t5_hold", int'(v_a), 6);
    config_en = 1'b0; syn_in = 4'b0001; decay_sel = 3'd0;
    tick(); check("t5_resume", int'(v_a), 9);

    // Soft reset in refractory, then async reset during FIRE.
    soft_reset();
    u_t = 4'd0; syn_in = 4'b0000;
    tick(); tick();
    reset_nn = 1'b1;
    tick(); check("t6_nn_spk", int'(spk_a), 0);
    reset_nn = 1'b0;
    tick(); check("t6_refire", int'(spk_a), 1);
    async_rst();
    check("t6_rst_spk", int'(spk_a), 0);
    tick(); check("t6_rst_refire", int'(spk_a), 1);

    // Randomised operation.
    for (int k = 0; k < 500; k++) begin
      w         = 12'($urandom);
      u_t       = 4'($urandom);
      decay_sel = 3'($urandom);
      clockbus  = {6'($urandom), 2'b10};
      syn_in    = 4'($urandom);
      config_en = ($urandom_range(0, 9) == 0);
      reset_nn  = ($urandom_range(0, 39) == 0);
      tick();
      if ($urandom_range(0, 59) == 0) async_rst();
    end
    reset_nn  = 1'b0;
    config_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
